// File: rtl/tiger_debug_irq_mc.sv
// Tiger debug interrupt controller: a JTAG-shifted request vector is carried per channel
// into the clk domain by a 4-phase req/ack handshake and exposed through an Avalon slave.
module tiger_debug_irq_mc #(
    parameter int unsigned N_CHAN      = 4,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        tck,
    input  logic        tdi,
    input  logic        sdr,
    input  logic        udr,
    input  logic [1:0]  avs_debugSlave_address,
    input  logic        avs_debugSlave_read,
    input  logic        avs_debugSlave_write,
    input  logic [31:0] avs_debugSlave_writedata,
    output logic [31:0] avs_debugSlave_readdata,
    output logic        avs_debugSlave_irq
);
    typedef enum logic [1:0] {
        REG_PENDING = 2'd0,
        REG_MASK    = 2'd1,
        REG_BUSY    = 2'd2,
        REG_CTRL    = 2'd3
    } regSel_t;

    regSel_t regSel;

    // tck domain
    logic [N_CHAN-1:0] shreg;
    logic [N_CHAN-1:0] req;
    logic [N_CHAN-1:0] ackSync [SYNC_STAGES];
    logic [N_CHAN:0]   shExt;
    logic [N_CHAN-1:0] shNext;
    logic [N_CHAN-1:0] reqNext;

    // clk domain
    logic [N_CHAN-1:0] reqSync [SYNC_STAGES];
    logic [N_CHAN-1:0] rLast;
    logic [N_CHAN-1:0] ack;
    logic [N_CHAN-1:0] pending;
    logic [N_CHAN-1:0] mask;
    logic [N_CHAN-1:0] rise;
    logic [N_CHAN-1:0] busy;
    logic [N_CHAN-1:0] ackNext;
    logic [N_CHAN-1:0] pendingNext;
    logic [N_CHAN-1:0] maskNext;
    logic [31:0]       rdMux;
    logic              unusedWdata;

    assign unusedWdata = ^avs_debugSlave_writedata;
    assign regSel      = regSel_t'(avs_debugSlave_address);

    always_comb begin
        shExt  = {tdi, shreg};
        shNext = sdr ? shExt[N_CHAN:1] : shreg;
        // A returning ack masks the udr set, so an in-flight channel cannot re-arm this cycle.
        reqNext = (req | (udr ? shreg : '0)) & ~ackSync[SYNC_STAGES-1];
    end

    always_ff @(posedge tck or negedge reset_n) begin
        if (!reset_n) begin
            shreg <= '0;
            req   <= '0;
            for (int unsigned s = 0; s < SYNC_STAGES; s++) ackSync[s] <= '0;
        end else begin
            shreg      <= shNext;
            req        <= reqNext;
            ackSync[0] <= ack;
            for (int unsigned s = 1; s < SYNC_STAGES; s++) ackSync[s] <= ackSync[s-1];
        end
    end

    always_comb begin
        rise    = reqSync[SYNC_STAGES-1] & ~rLast;
        busy    = reqSync[SYNC_STAGES-1] | ack;
        ackNext = (ack | rise) & reqSync[SYNC_STAGES-1];

        pendingNext = pending;
        maskNext    = mask;
        if (avs_debugSlave_write) begin
            case (regSel)
                REG_PENDING: pendingNext = pending & ~avs_debugSlave_writedata[N_CHAN-1:0];
                REG_MASK:    maskNext = avs_debugSlave_writedata[N_CHAN-1:0];
                REG_CTRL:    if (avs_debugSlave_writedata[0]) pendingNext = '0;
                default:     ;
            endcase
        end
        // Arrivals are applied after the clear so that set beats clear on the same bit.
        pendingNext = pendingNext | rise;

        rdMux = '0;
        case (regSel)
            REG_PENDING: rdMux[N_CHAN-1:0] = pending;
            REG_MASK:    rdMux[N_CHAN-1:0] = mask;
            REG_BUSY:    rdMux[N_CHAN-1:0] = busy;
            default:     rdMux = '0;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int unsigned s = 0; s < SYNC_STAGES; s++) reqSync[s] <= '0;
            rLast                   <= '0;
            ack                     <= '0;
            pending                 <= '0;
            mask                    <= '1;
            avs_debugSlave_irq      <= 1'b0;
            avs_debugSlave_readdata <= '0;
        end else begin
            reqSync[0] <= req;
            for (int unsigned s = 1; s < SYNC_STAGES; s++) reqSync[s] <= reqSync[s-1];
            rLast              <= reqSync[SYNC_STAGES-1];
            ack                <= ackNext;
            pending            <= pendingNext;
            mask               <= maskNext;
            avs_debugSlave_irq <= |(pending & mask);
            if (avs_debugSlave_read) avs_debugSlave_readdata <= rdMux;
        end
    end
endmodule

// File: tb/tb_tiger_debug_irq_mc.sv
// Bench for tiger_debug_irq_mc: event-level model of arrivals/registers checked every clk,
// plus literal expectations for the directed scenarios.
module tb_tiger_debug_irq_mc;
    localparam int N          = 4;
    localparam int SS         = 2;
    localparam int FLIGHT_TCK = 16;

    logic        clk = 1'b0;
    logic        tck = 1'b0;
    logic        reset_n = 1'b1;
    logic        tdi = 1'b0;
    logic        sdr = 1'b0;
    logic        udr = 1'b0;
    logic [1:0]  address = 2'd0;
    logic        rd = 1'b0;
    logic        wr = 1'b0;
    logic [31:0] wdata = '0;
    logic [31:0] readdata;
    logic        irq;

    int nRun = 0;
    int nFail = 0;
    logic jtagBusy = 1'b0;

    // Model state
    logic [N-1:0] pendM, maskM, arrM, shM, inFlight;
    logic         irqM;
    logic [31:0]  rdM;
    logic         rdKnown;
    int           cnt [N];
    int           seenAcc [N];
    int           accCnt [N];
    int           age [N];

    tiger_debug_irq_mc #(.N_CHAN(N), .SYNC_STAGES(SS)) dut (
        .clk(clk), .reset_n(reset_n), .tck(tck), .tdi(tdi), .sdr(sdr), .udr(udr),
        .avs_debugSlave_address(address), .avs_debugSlave_read(rd),
        .avs_debugSlave_write(wr), .avs_debugSlave_writedata(wdata),
        .avs_debugSlave_readdata(readdata), .avs_debugSlave_irq(irq)
    );

    // Edges never coincide: clk rises at odd multiples of 5, tck edges at multiples of 8.
    always #5 clk = ~clk;
    always #8 tck = ~tck;

    // JTAG side: a request is accepted unless its channel is still inside a round trip.
    initial forever begin
        @(posedge tck or negedge reset_n);
        if (!reset_n) begin
            shM = '0;
            inFlight = '0;
            for (int i = 0; i < N; i++) age[i] = 0;
        end else begin
            for (int i = 0; i < N; i++)
                if (inFlight[i]) begin
                    age[i]++;
                    if (age[i] >= FLIGHT_TCK) inFlight[i] = 1'b0;
                end
            if (udr)
                for (int i = 0; i < N; i++)
                    if (shM[i] && !inFlight[i]) begin
                        inFlight[i] = 1'b1;
                        age[i] = 0;
                        accCnt[i]++;
                    end
            if (sdr) shM = {tdi, shM[N-1:1]};
        end
    end

    // clk side: an accepted request lands in pending SS+1 clk edges later.
    initial forever begin
        @(posedge clk or negedge reset_n);
        if (!reset_n) begin
            pendM = '0; maskM = '1; irqM = 1'b0; rdM = '0; rdKnown = 1'b1;
            for (int i = 0; i < N; i++) begin cnt[i] = 0; seenAcc[i] = accCnt[i]; end
        end else begin
            irqM = |(pendM & maskM);
            if (rd) begin
                rdKnown = (address != 2'd2);
                case (address)
                    2'd0:    rdM = {28'd0, pendM};
                    2'd1:    rdM = {28'd0, maskM};
                    default: rdM = '0;
                endcase
            end
            arrM = '0;
            for (int i = 0; i < N; i++) begin
                if (cnt[i] > 0) begin
                    cnt[i]--;
                    if (cnt[i] == 0) arrM[i] = 1'b1;
                end
                if (accCnt[i] != seenAcc[i]) begin seenAcc[i] = accCnt[i]; cnt[i] = SS; end
            end
            if (wr && address == 2'd0) pendM = pendM & ~wdata[N-1:0];
            if (wr && address == 2'd1) maskM = wdata[N-1:0];
            if (wr && address == 2'd3 && wdata[0]) pendM = '0;
            pendM = pendM | arrM;
        end
    end

    task automatic step();
        @(negedge clk);
        nRun++;
        if (irq !== irqM) begin
            nFail++;
            $display("FAIL irq_cycle t=%0t: got %b want %b", $time, irq, irqM);
        end
        if (rdKnown) begin
            nRun++;
            if (readdata !== rdM) begin
                nFail++;
                $display("FAIL readdata_cycle t=%0t: got 0x%0h want 0x%0h", $time, readdata, rdM);
            end
        end
    endtask

    task automatic expectVal(input string name, input logic [31:0] got, input logic [31:0] want);
        nRun++;
        if (got !== want) begin
            nFail++;
            $display("FAIL %s: got 0x%0h want 0x%0h", name, got, want);
        end
    endtask

    task automatic avRead(input logic [1:0] a, output logic [31:0] d);
        address = a; rd = 1'b1;
        step();
        rd = 1'b0;
        d = readdata;
    endtask

    task automatic avWrite(input logic [1:0] a, input logic [31:0] d);
        address = a; wdata = d; wr = 1'b1;
        step();
        wr = 1'b0;
    endtask

    task automatic jtagSend(input logic [N-1:0] v, input int pulses);
        @(negedge tck);
        for (int i = 0; i < N; i++) begin
            sdr = 1'b1; tdi = v[i];
            @(negedge tck);
        end
        sdr = 1'b0; tdi = 1'b0;
        for (int p = 0; p < pulses; p++) begin
            udr = 1'b1;
            @(negedge tck);
        end
        udr = 1'b0;
        jtagBusy = 1'b0;
    endtask

    task automatic startJtag(input logic [N-1:0] v, input int pulses);
        jtagBusy = 1'b1;
        fork
            jtagSend(v, pulses);
        join_none
    endtask

    task automatic waitJtag();
        int guard;
        guard = 0;
        while (jtagBusy && guard < 500) begin step(); guard++; end
        expectVal("jtag_done", {31'd0, jtagBusy}, 32'd0);
    endtask

    logic [31:0] d;
    logic        sawBusy;
    int          guard;

    initial begin
        #1 reset_n = 1'b0;
        repeat (3) step();
        reset_n = 1'b1;

        // Reset state
        avRead(2'd0, d); expectVal("rst_pending", d, 32'h0);
        avRead(2'd1, d); expectVal("rst_mask", d, 32'hF);
        avRead(2'd2, d); expectVal("rst_busy", d, 32'h0);
        avRead(2'd3, d); expectVal("rst_ctrl", d, 32'h0);

        // 1: single request on channel 2, busy rises then drains
        startJtag(4'b0100, 1);
        waitJtag();
        sawBusy = 1'b0;
        for (int k = 0; k < 80; k++) begin
            avRead(2'd2, d);
            if (d != 0) sawBusy = 1'b1;
            if (sawBusy && d == 0) break;
        end
        expectVal("t1_busy_seen", {31'd0, sawBusy}, 32'd1);
        expectVal("t1_busy_drained", d, 32'h0);
        avRead(2'd0, d); expectVal("t1_pending", d, 32'h4);
        expectVal("t1_irq", {31'd0, irq}, 32'd1);

        // 2: W1C, irq falls one clk later
        avWrite(2'd0, 32'h4);
        step();
        expectVal("t2_irq", {31'd0, irq}, 32'd0);
        avRead(2'd0, d); expectVal("t2_pending", d, 32'h0);
        avRead(2'd1, d); expectVal("t2_mask", d, 32'hF);

        // 3: masked arrival, then unmask
        avWrite(2'd1, 32'h1);
        startJtag(4'b0010, 1);
        waitJtag();
        repeat (10) step();
        avRead(2'd0, d); expectVal("t3_pending", d, 32'h2);
        expectVal("t3_irq_masked", {31'd0, irq}, 32'd0);
        avWrite(2'd1, 32'h3);
        step();
        expectVal("t3_irq_unmasked", {31'd0, irq}, 32'd1);
        avWrite(2'd0, 32'h2);
        repeat (40) step();

        // 4: repeated udr while channel 0 is in flight merges into one arrival
        startJtag(4'b0001, 3);
        waitJtag();
        repeat (10) step();
        avRead(2'd0, d); expectVal("t4_pending", d, 32'h1);
        avWrite(2'd0, 32'h1);
        repeat (60) step();
        avRead(2'd0, d); expectVal("t4_no_reassert", d, 32'h0);
        expectVal("t4_irq", {31'd0, irq}, 32'd0);

        // 5: W1C of bit 3 on the arrival edge; set wins
        avWrite(2'd1, 32'hF);
        startJtag(4'b1000, 1);
        guard = 0;
        do begin step(); guard++; end while (cnt[3] != 1 && guard < 300);
        expectVal("t5_arrival_window", {31'd0, guard < 300}, 32'd1);
        address = 2'd0; wdata = 32'h8; wr = 1'b1;
        step();
        wr = 1'b0;
        avRead(2'd0, d); expectVal("t5_pending", d, 32'h8);
        expectVal("t5_irq", {31'd0, irq}, 32'd1);
        waitJtag();
        avWrite(2'd3, 32'h1);
        avRead(2'd0, d); expectVal("t5_ctrl_clear", d, 32'h0);
        avRead(2'd3, d); expectVal("t5_ctrl_read", d, 32'h0);
        repeat (40) step();

        // 6: reset mid-handshake (req high, ack still low)
        startJtag(4'b0100, 1);
        guard = 0;
        do begin step(); guard++; end while (cnt[2] != SS && guard < 300);
        expectVal("t6_inflight_window", {31'd0, guard < 300}, 32'd1);
        reset_n = 1'b0;
        repeat (3) step();
        reset_n = 1'b1;
        avRead(2'd0, d); expectVal("t6_pending", d, 32'h0);
        avRead(2'd1, d); expectVal("t6_mask", d, 32'hF);
        avRead(2'd2, d); expectVal("t6_busy", d, 32'h0);
        repeat (20) step();
        avRead(2'd0, d); expectVal("t6_no_survivor", d, 32'h0);
        waitJtag();
        startJtag(4'b0100, 1);
        waitJtag();
        repeat (10) step();
        avRead(2'd0, d); expectVal("t6_new_pending", d, 32'h4);
        expectVal("t6_new_irq", {31'd0, irq}, 32'd1);
        repeat (5) step();

        $display("[TB] %0d tests run, %0d failed", nRun, nFail);
        $finish;
    end
endmodule
